poly_add_ctrl: RTL and testbench

Sequencer for coefficient-wise modular addition or subtraction of two length-N polynomials held in single-port-read coefficient RAMs. On `start` it streams addresses 0..N-1 to both operand RAMs and feeds each returned coefficient pair through a registered modular add/sub stage. It writes each reduced result to the result RAM and pulses `done` when the last coefficient has been written. It sits between the top-level PKC controller and the polynomial memories, replacing register-wide accumulation with RAM-streamed operation.

---
 rtl/pqc_pkg.sv | 16 +
 rtl/mod_addsub.sv | 41 ++++
 rtl/poly_add_ctrl.sv | 129 ++++++++++++
 tb/tb_poly_add_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pqc_pkg.sv
// Shared constants and state encoding for the polynomial arithmetic blocks.
package pqc_pkg;

  localparam int unsigned P    = 1049089;
  localparam int unsigned N    = 256;
  localparam int unsigned B    = 21;
  localparam int unsigned LOGN = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/mod_addsub.sv
// Registered single-cycle modular add/subtract: y <= (a +/- b) mod P.
// Operands below P need only one correction step.
module mod_addsub
  import pqc_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         sub,
  input  logic [B-1:0] a,
  input  logic [B-1:0] b,
  output logic [B-1:0] y
);

  localparam logic [B:0] P_EXT = (B+1)'(P);

  logic [B:0]   sum;
  logic [B:0]   diff;
  logic [B-1:0] y_c;

  // A negative difference shows up as the extra top bit set.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    y_c  = '0;
    if (sub) begin
      y_c = diff[B] ? B'(diff + P_EXT) : B'(diff);
    end else begin
      y_c = (sum >= P_EXT) ? B'(sum - P_EXT) : B'(sum);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y <= '0;
    end else if (en) begin
      y <= y_c;
    end
  end

endmodule

// File: rtl/poly_add_ctrl.sv
// Streams coefficient pairs 0..N-1 from the operand RAMs through mod_addsub
// into the result RAM; one coefficient per cycle, done pulse at the end.
module poly_add_ctrl
  import pqc_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            sub,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr,
  input  logic [B-1:0]    a_coef,
  input  logic [B-1:0]    b_coef,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr,
  output logic [B-1:0]    wr_data
);

  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

  state_t          state;
  state_t          state_nxt;
  logic [LOGN-1:0] cnt_nxt;
  logic            drain_cnt;
  logic            drain_nxt;
  logic            sub_q;
  logic            sub_nxt;
  logic            busy_nxt;
  logic            done_nxt;
  logic            rd_en_nxt;
  logic            v1;
  logic [LOGN-1:0] a1;

  // Next state and next registered outputs; rd_addr doubles as the read counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = rd_addr;
    drain_nxt = drain_cnt;
    sub_nxt   = sub_q;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    rd_en_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          sub_nxt   = sub;
          busy_nxt  = 1'b1;
          rd_en_nxt = 1'b1;
        end
      end
      RUN: begin
        if (rd_addr == LAST) begin
          state_nxt = DRAIN;
          drain_nxt = 1'b0;
        end else begin
          cnt_nxt   = rd_addr + LOGN'(1);
          rd_en_nxt = 1'b1;
        end
      end
      DRAIN: begin
        // Two cycles: RAM read latency plus the arithmetic register.
        if (drain_cnt) begin
          state_nxt = FIN;
          done_nxt  = 1'b1;
        end else begin
          drain_nxt = 1'b1;
        end
      end
      FIN: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rd_addr   <= '0;
      drain_cnt <= 1'b0;
      sub_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_addr   <= cnt_nxt;
      drain_cnt <= drain_nxt;
      sub_q     <= sub_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      rd_en     <= rd_en_nxt;
    end
  end

  // Delay line: RAM latency stage, then aligned with the arithmetic register.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1      <= 1'b0;
      a1      <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
    end else begin
      v1      <= rd_en;
      a1      <= rd_addr;
      wr_en   <= v1;
      wr_addr <= a1;
    end
  end

  mod_addsub u_addsub (
    .clk   (clk),
    .reset (reset),
    .en    (v1),
    .sub   (sub_q),
    .a     (a_coef),
    .b     (b_coef),
    .y     (wr_data)
  );

endmodule

// File: tb/tb_poly_add_ctrl.sv
// Directed bench for poly_add_ctrl: RAM models, write/read monitor, vector table.
module tb_poly_add_ctrl;
  import pqc_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            sub;
  logic            busy;
  logic            done;
  logic            rd_en;
  logic [LOGN-1:0] rd_addr;
  logic [B-1:0]    a_coef;
  logic [B-1:0]    b_coef;
  logic            wr_en;
  logic [LOGN-1:0] wr_addr;
  logic [B-1:0]    wr_data;

  logic [B-1:0] a_mem [N];
  logic [B-1:0] b_mem [N];
  logic [B-1:0] res   [N];

  int cyc = 0, t0 = 0, nchk = 0, nerr = 0;
  int rd_cnt, rd_bad, wr_cnt, wr_bad, last_wr, done_cnt, done_cyc;

  typedef struct {
    int   addr;
    logic mode;
    int   a;
    int   b;
    int   exp;
  } vec_t;
  vec_t vecs [10];

  poly_add_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .sub     (sub),
    .busy    (busy),
    .done    (done),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .a_coef  (a_coef),
    .b_coef  (b_coef),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Operand RAMs with one cycle of read latency.
  always @(posedge clk) begin
    if (rd_en) begin
      a_coef <= a_mem[rd_addr];
      b_coef <= b_mem[rd_addr];
    end
  end

  // Cycle numbers are relative to the start edge: cycle 1 follows it.
  always @(negedge clk) begin
    int rel;
    rel = cyc - t0 + 1;
    if (rd_en) begin
      rd_cnt++;
      if (int'(rd_addr) != rel - 1) rd_bad++;
    end
    if (wr_en) begin
      wr_cnt++;
      if (int'(wr_addr) != rel - 3) wr_bad++;
      res[wr_addr] = wr_data;
      last_wr = rel;
    end
    if (done) begin
      done_cnt++;
      done_cyc = rel;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic begin_op();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    t0 = cyc;
    rd_cnt = 0; rd_bad = 0; wr_cnt = 0; wr_bad = 0;
    last_wr = -1; done_cnt = 0; done_cyc = -1;
    for (int k = 0; k < int'(N); k++) res[k] = '1;
  endtask

  task automatic finish_op(input string tag);
    int i;
    i = 0;
    while (done_cnt == 0 && i < 400) begin
      @(posedge clk);
      i++;
    end
    #1;
    chk({tag, "_done_cyc"}, done_cyc, int'(N) + 3);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_rd_cnt"}, rd_cnt, int'(N));
    chk({tag, "_rd_addr_bad"}, rd_bad, 0);
    chk({tag, "_wr_cnt"}, wr_cnt, int'(N));
    chk({tag, "_wr_timing_bad"}, wr_bad, 0);
    chk({tag, "_last_wr"}, last_wr, int'(N) + 2);
    chk({tag, "_busy_after"}, int'(busy), 0);
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < int'(N); k++) begin
      a_mem[k] = B'(k);
      b_mem[k] = B'(2 * k);
    end
  endtask

  task automatic check_ramp(input string tag, input logic mode);
    int bad, exp;
    bad = 0;
    for (int k = 0; k < int'(N); k++) begin
      exp = mode ? ((k == 0) ? 0 : int'(P) - k) : 3 * k;
      if (int'(res[k]) != exp) bad++;
    end
    chk({tag, "_data_bad"}, bad, 0);
  endtask

  initial begin
    vecs[0] = '{0, 1'b0, 1049088, 1,       0};
    vecs[1] = '{1, 1'b0, 1049088, 1049088, 1049087};
    vecs[2] = '{2, 1'b0, 1049088, 0,       1049088};
    vecs[3] = '{3, 1'b0, 524544,  524545,  0};
    vecs[4] = '{4, 1'b0, 524544,  524544,  1049088};
    vecs[5] = '{0, 1'b1, 0,       1,       1049088};
    vecs[6] = '{1, 1'b1, 5,       5,       0};
    vecs[7] = '{2, 1'b1, 1049088, 0,       1049088};
    vecs[8] = '{3, 1'b1, 0,       1049088, 1};
    vecs[9] = '{4, 1'b1, 1000,    1,       999};

    reset = 1'b1;
    start = 1'b1;
    sub   = 1'b0;
    fill_ramp();

    // Reset wins over a held start.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ctl", int'({busy, done, rd_en, wr_en}), 0);
      chk("rst_data", int'(rd_addr) + int'(wr_addr) + int'(wr_data), 0);
    end
    @(posedge clk);
    #1 reset = 1'b0;

    // Start still high: accepted on the first edge after reset drops.
    begin_op();
    chk("post_rst_busy", int'(busy), 1);
    chk("post_rst_rd_en", int'(rd_en), 1);
    chk("post_rst_rd_addr", int'(rd_addr), 0);
    finish_op("ramp_add");
    check_ramp("ramp_add", 1'b0);

    // Vector table: wrap-around add and subtract corners.
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < int'(N); k++) begin
        a_mem[k] = '0;
        b_mem[k] = '0;
      end
      for (int i = 0; i < 10; i++) begin
        if (int'(vecs[i].mode) == m) begin
          a_mem[vecs[i].addr] = B'(vecs[i].a);
          b_mem[vecs[i].addr] = B'(vecs[i].b);
        end
      end
      sub = m[0];
      begin_op();
      finish_op($sformatf("table_m%0d", m));
      for (int i = 0; i < 10; i++) begin
        if (int'(vecs[i].mode) == m)
          chk($sformatf("vec%0d", i), int'(res[vecs[i].addr]), vecs[i].exp);
      end
    end

    // Reset asserted in cycle 100 of an add.
    fill_ramp();
    sub = 1'b0;
    begin_op();
    repeat (99) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("abort_done_cnt", done_cnt, 0);
    chk("abort_wr_cnt", wr_cnt, 98);
    chk("abort_last_wr", last_wr, 100);
    chk("abort_busy", int'(busy), 0);
    begin_op();
    finish_op("restart");
    check_ramp("restart", 1'b0);

    // Ignored start pulses, sub toggle mid-run, then back-to-back subtract.
    sub = 1'b0;
    begin_op();
    repeat (49) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 sub = 1'b1;
    repeat (int'(N) - 59) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    finish_op("b2b1");
    check_ramp("b2b1", 1'b0);
    begin_op();
    finish_op("b2b2");
    check_ramp("b2b2", 1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
